bmp_stream_sequencer: RTL and testbench
=======================================

# bmp_stream_sequencer

Frame-level controller that sequences one BMP read stream, a fixed-latency pixel-processing pipeline and one BMP write stream. It drives the stream `rst`/`reload` controls and validates the 60-byte packed header. It issues per-pixel valid, coordinate and last markers to the pipeline, and times writer release so that pixel 0 reaches the writer on its first write cycle. It sits at testbench/top level, between the stimulus FSM and the reader, pipeline and writer instances.

## Interface
- `PIPE_LAT`, 2: clock cycles from reader output to writer input through the pipeline (0..255).
- `MAX_W`, 4096: largest accepted image width in pixels.
- `MAX_H`, 4096: largest accepted image height in pixels.
- `TIMEOUT`, 64: cycles allowed in DRAIN for `wr_end` to assert.

- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `start`  in  1  one-cycle request to process one frame; sampled in IDLE only.
- `abort`  in  1  return to IDLE from any state.
- `bmp_header`  in  480  packed header bytes from the reader; byte n = bits [8n+7:8n].
- `rd_end`  in  1  reader end-of-image flag.
- `wr_end`  in  1  writer end-of-image flag.
- `rd_rst`  out  1  reader reset/load control.
- `rd_reload`  out  1  reader file-load request.
- `wr_rst`  out  1  writer reset/header-write control.
- `pix_valid`  out  1  reader output pixel is a real image pixel.
- `pix_last`  out  1  with `pix_valid`, final pixel of the frame.
- `pix_x`  out  16  column of the current pixel.
- `pix_y`  out  16  row of the current pixel.
- `busy`  out  1  high in every state except IDLE and ERR.
- `done`  out  1  one-cycle frame-complete pulse.
- `err`  out  1  sticky error flag.

## Operation
- States: IDLE, LOAD, HDR, STREAM, DRAIN, DONE, ERR.
- Reset values:
  - `rd_rst`=1, `wr_rst`=1.
  - `rd_reload`, `pix_valid`, `pix_last`, `busy`, `done`, `err` = 0.
  - `pix_x`=0, `pix_y`=0.
  - State = IDLE.
- IDLE: `rd_rst`=1, `wr_rst`=1. `start` with `abort` low goes to LOAD.
- LOAD (1 cycle): `rd_rst`=1, `rd_reload`=1. Goes to HDR.
- HDR (1 cycle): `rd_rst`=1, `wr_rst`=1.
  - Latches W = header bytes 21..18 and H = header bytes 25..22, both little-endian, 32 bits.
  - Goes to ERR if W=0, H=0, W>MAX_W or H>MAX_H; otherwise to STREAM.
  - Latches total = W*H, 32 bits; cannot overflow under the default limits.
- STREAM:
  - `rd_rst`=0, `pix_valid`=1.
  - `pix_x` counts 0..W-1, then wraps to 0 and increments `pix_y`.
  - `pix_last`=1 when the pixel count equals total-1; the next state is DRAIN.
  - Latency counter `lc` starts at 0 on STREAM entry. `wr_rst` stays 1 while `lc`<PIPE_LAT, then drops to 0 and stays 0 through DRAIN. With PIPE_LAT=0, `wr_rst` falls in the first STREAM cycle.
- DRAIN:
  - `rd_rst`=1, `pix_valid`=0. `lc` keeps counting; `wr_rst` is released here if not already low.
  - `wr_end`=1 goes to DONE.
  - The timeout counter starts at 0 on DRAIN entry. Reaching TIMEOUT without `wr_end` goes to ERR.
- DONE (1 cycle): `done`=1, `rd_rst`=1, `wr_rst`=1. Goes to IDLE.
- ERR: `rd_rst`=1, `wr_rst`=1, `err`=1, `busy`=0.
  - Stays until `start` or `abort`; either clears `err` and goes to IDLE.
  - `start` in ERR does not launch a frame.
- `rd_end` rising in STREAM before `pix_last` is an error and goes to ERR next cycle.
- `abort` (synchronous) has priority over all transitions:
  - Next state is IDLE; counters clear; no `done`.
  - `err` clears only when aborting from ERR.
- `start` outside IDLE/ERR is ignored.

## Timing
- All outputs are registered; each one changes on the cycle its state/counter condition becomes true.
- `start` at edge k: LOAD at k+1, HDR at k+2, first STREAM cycle at k+3.
- The STREAM dwell is exactly W*H cycles; `pix_last` is asserted in the last of them.
- `wr_rst` falls exactly PIPE_LAT cycles after `rd_rst` falls.
- Asynchronous `rst` mid-frame forces all reset values immediately, independent of `clk`.

## Test plan
- W=4, H=2, PIPE_LAT=2:
  - `pix_valid` high 8 cycles; `pix_x` 0,1,2,3,0,1,2,3; `pix_y` 0×4 then 1×4.
  - `pix_last` on the 8th cycle; `wr_rst` falls 2 cycles after `rd_rst`.
  - `wr_end` 3 cycles into DRAIN → `done` 1 cycle, then IDLE.
- PIPE_LAT=0, W=3, H=1: `rd_rst` and `wr_rst` fall on the same edge; 3 valid pixels; `pix_last` on the 3rd.
- W=0, and separately H=5000: ERR 2 cycles after LOAD with `err`=1 and `busy`=0; a following `start` clears to IDLE.
- `wr_end` held 0: ERR after exactly 64 DRAIN cycles; `rd_rst`=`wr_rst`=1.
- `abort` at STREAM pixel 3: IDLE next cycle, `pix_valid`=0, no `done`.
- Async `rst` pulse mid-STREAM between clock edges: outputs take reset values before the next edge.

Source files
------------

// File: rtl/bmp_stream_sequencer_if.sv
// Stream-side bundle between the frame sequencer and the reader/pipeline/writer.
// master: sequencer side (drives stream controls and pixel markers); slave: peer side.
interface bmp_stream_sequencer_if;
    logic [479:0] bmp_header;
    logic         rd_end;
    logic         wr_end;
    logic         rd_rst;
    logic         rd_reload;
    logic         wr_rst;
    logic         pix_valid;
    logic         pix_last;
    logic [15:0]  pix_x;
    logic [15:0]  pix_y;

    modport master (
        input  bmp_header, rd_end, wr_end,
        output rd_rst, rd_reload, wr_rst,
        output pix_valid, pix_last, pix_x, pix_y
    );

    modport slave (
        output bmp_header, rd_end, wr_end,
        input  rd_rst, rd_reload, wr_rst,
        input  pix_valid, pix_last, pix_x, pix_y
    );
endinterface

// File: rtl/bmp_stream_sequencer.sv
// Frame controller: loads one BMP, validates its header, streams W*H pixels
// through a PIPE_LAT-deep pipeline and waits for the writer to finish.
// Ports: clk, rst (async, active-high), start, abort, bus (stream bundle),
// busy/done/err status. All outputs are registered.
module bmp_stream_sequencer #(
    parameter int unsigned PIPE_LAT = 2,
    parameter int unsigned MAX_W    = 4096,
    parameter int unsigned MAX_H    = 4096,
    parameter int unsigned TIMEOUT  = 64
) (
    input  logic clk,
    input  logic rst,
    input  logic start,
    input  logic abort,
    bmp_stream_sequencer_if.master bus,
    output logic busy,
    output logic done,
    output logic err
);
    localparam logic [8:0]  LAT      = 9'(PIPE_LAT);
    localparam logic [31:0] WMAX     = 32'(MAX_W);
    localparam logic [31:0] HMAX     = 32'(MAX_H);
    localparam logic [31:0] TMO_LAST = 32'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_HDR, S_STREAM, S_DRAIN, S_DONE, S_ERR
    } state_t;

    state_t      state, state_d;
    logic [15:0] w_q, w_d;
    logic [31:0] tot_q, tot_d;
    logic [31:0] cnt_q, cnt_d;
    logic [15:0] x_d, y_d;
    logic [8:0]  lc_q, lc_d, lc_sat;
    logic [31:0] tmo_q, tmo_d;
    logic        rd_end_q;
    logic [31:0] hdr_w, hdr_h;
    logic        rd_rst_d, wr_rst_d, reload_d;
    logic        valid_d, last_d;
    logic        in_flow;

    // Width at bytes 18..21, height at bytes 22..25, little-endian.
    assign hdr_w = bus.bmp_header[175:144];
    assign hdr_h = bus.bmp_header[207:176];

    // Pipeline latency counter saturates once the writer may be released.
    assign lc_sat = (lc_q < LAT) ? lc_q + 9'd1 : lc_q;

    always_comb begin
        state_d = state;
        w_d     = w_q;
        tot_d   = tot_q;
        cnt_d   = '0;
        x_d     = '0;
        y_d     = '0;
        lc_d    = '0;
        tmo_d   = '0;
        unique case (state)
            S_IDLE: if (start) state_d = S_LOAD;
            S_LOAD: state_d = S_HDR;
            S_HDR: begin
                w_d   = hdr_w[15:0];
                tot_d = hdr_w * hdr_h;
                if (hdr_w == 0 || hdr_h == 0 || hdr_w > WMAX || hdr_h > HMAX)
                    state_d = S_ERR;
                else
                    state_d = S_STREAM;
            end
            S_STREAM: begin
                lc_d = lc_sat;
                if (bus.pix_last) begin
                    state_d = S_DRAIN;
                end else if (bus.rd_end && !rd_end_q) begin
                    // Reader ran out before the frame was complete.
                    state_d = S_ERR;
                end else begin
                    cnt_d = cnt_q + 32'd1;
                    if (bus.pix_x == w_q - 16'd1) begin
                        x_d = '0;
                        y_d = bus.pix_y + 16'd1;
                    end else begin
                        x_d = bus.pix_x + 16'd1;
                        y_d = bus.pix_y;
                    end
                end
            end
            S_DRAIN: begin
                lc_d = lc_sat;
                if (bus.wr_end)
                    state_d = S_DONE;
                else if (tmo_q == TMO_LAST)
                    state_d = S_ERR;
                else
                    tmo_d = tmo_q + 32'd1;
            end
            S_DONE: state_d = S_IDLE;
            S_ERR:  if (start) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            x_d     = '0;
            y_d     = '0;
            lc_d    = '0;
            tmo_d   = '0;
        end
    end

    // Registered outputs follow the state/counters being entered.
    always_comb begin
        in_flow  = (state_d == S_STREAM) || (state_d == S_DRAIN);
        rd_rst_d = (state_d != S_STREAM);
        wr_rst_d = !(in_flow && lc_d >= LAT);
        reload_d = (state_d == S_LOAD);
        valid_d  = (state_d == S_STREAM);
        last_d   = (state_d == S_STREAM) && (cnt_d == tot_d - 32'd1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            w_q           <= '0;
            tot_q         <= '0;
            cnt_q         <= '0;
            lc_q          <= '0;
            tmo_q         <= '0;
            rd_end_q      <= 1'b0;
            bus.rd_rst    <= 1'b1;
            bus.wr_rst    <= 1'b1;
            bus.rd_reload <= 1'b0;
            bus.pix_valid <= 1'b0;
            bus.pix_last  <= 1'b0;
            bus.pix_x     <= '0;
            bus.pix_y     <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            err           <= 1'b0;
        end else begin
            state         <= state_d;
            w_q           <= w_d;
            tot_q         <= tot_d;
            cnt_q         <= cnt_d;
            lc_q          <= lc_d;
            tmo_q         <= tmo_d;
            rd_end_q      <= bus.rd_end;
            bus.rd_rst    <= rd_rst_d;
            bus.wr_rst    <= wr_rst_d;
            bus.rd_reload <= reload_d;
            bus.pix_valid <= valid_d;
            bus.pix_last  <= last_d;
            bus.pix_x     <= x_d;
            bus.pix_y     <= y_d;
            busy          <= (state_d != S_IDLE) && (state_d != S_ERR);
            done          <= (state_d == S_DONE);
            err           <= (state_d == S_ERR);
        end
    end
endmodule

// File: tb/tb_bmp_stream_sequencer.sv
// Directed bench for bmp_stream_sequencer: one instance with PIPE_LAT=2,
// one with PIPE_LAT=0, hand-computed expectations per cycle.
module tb_bmp_stream_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start_a = 1'b0, abort_a = 1'b0;
    logic start_b = 1'b0, abort_b = 1'b0;
    logic busy_a, done_a, err_a;
    logic busy_b, done_b, err_b;
    int   n_cmp = 0;
    int   n_bad = 0;

    bmp_stream_sequencer_if ia ();
    bmp_stream_sequencer_if ib ();

    bmp_stream_sequencer #(.PIPE_LAT(2)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .abort(abort_a),
        .bus(ia.master), .busy(busy_a), .done(done_a), .err(err_a)
    );

    bmp_stream_sequencer #(.PIPE_LAT(0)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .abort(abort_b),
        .bus(ib.master), .busy(busy_b), .done(done_b), .err(err_b)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [479:0] mk_hdr(input logic [31:0] w,
                                            input logic [31:0] h);
        logic [479:0] v;
        v = '0;
        v[7:0]     = 8'h42;
        v[15:8]    = 8'h4d;
        v[175:144] = w;
        v[207:176] = h;
        return v;
    endfunction

    // Leaves dut_a in LOAD.
    task automatic launch_a(input logic [31:0] w, input logic [31:0] h);
        ia.bmp_header = mk_hdr(w, h);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
    endtask

    initial begin
        ia.bmp_header = '0;
        ia.rd_end = 1'b0;
        ia.wr_end = 1'b0;
        ib.bmp_header = '0;
        ib.rd_end = 1'b0;
        ib.wr_end = 1'b0;

        #13;
        chk("rst_rd_rst", ia.rd_rst, 1);
        chk("rst_wr_rst", ia.wr_rst, 1);
        chk("rst_valid", ia.pix_valid, 0);
        chk("rst_busy", busy_a, 0);
        chk("rst_err", err_a, 0);
        chk("rst_xy", {ia.pix_x, ia.pix_y}, 0);
        rst = 1'b0;
        step();

        // W=4 H=2 PIPE_LAT=2
        launch_a(4, 2);
        chk("t1_load_reload", ia.rd_reload, 1);
        chk("t1_load_busy", busy_a, 1);
        step();
        chk("t1_hdr_reload", ia.rd_reload, 0);
        chk("t1_hdr_rd_rst", ia.rd_rst, 1);
        for (int i = 0; i < 8; i++) begin
            step();
            chk($sformatf("t1_valid%0d", i), ia.pix_valid, 1);
            chk($sformatf("t1_x%0d", i), ia.pix_x, i % 4);
            chk($sformatf("t1_y%0d", i), ia.pix_y, i / 4);
            chk($sformatf("t1_last%0d", i), ia.pix_last, (i == 7));
            chk($sformatf("t1_rd_rst%0d", i), ia.rd_rst, 0);
            chk($sformatf("t1_wr_rst%0d", i), ia.wr_rst, (i < 2));
        end
        step();
        chk("t1_drain_valid", ia.pix_valid, 0);
        chk("t1_drain_last", ia.pix_last, 0);
        chk("t1_drain_rd_rst", ia.rd_rst, 1);
        chk("t1_drain_wr_rst", ia.wr_rst, 0);
        step();
        step();
        step();
        ia.wr_end = 1'b1;
        step();
        ia.wr_end = 1'b0;
        chk("t1_done", done_a, 1);
        chk("t1_done_wr_rst", ia.wr_rst, 1);
        step();
        chk("t1_idle_done", done_a, 0);
        chk("t1_idle_busy", busy_a, 0);

        // PIPE_LAT=0, W=3 H=1
        ib.bmp_header = mk_hdr(3, 1);
        start_b = 1'b1;
        step();
        start_b = 1'b0;
        step();
        chk("t2_hdr_wr_rst", ib.wr_rst, 1);
        for (int i = 0; i < 3; i++) begin
            step();
            chk($sformatf("t2_rd_rst%0d", i), ib.rd_rst, 0);
            chk($sformatf("t2_wr_rst%0d", i), ib.wr_rst, 0);
            chk($sformatf("t2_valid%0d", i), ib.pix_valid, 1);
            chk($sformatf("t2_x%0d", i), ib.pix_x, i);
            chk($sformatf("t2_last%0d", i), ib.pix_last, (i == 2));
        end
        step();
        chk("t2_drain_valid", ib.pix_valid, 0);
        ib.wr_end = 1'b1;
        step();
        ib.wr_end = 1'b0;
        chk("t2_done", done_b, 1);
        step();

        // Header rejects: W=0, then H=5000
        for (int k = 0; k < 2; k++) begin
            if (k == 0) launch_a(0, 2);
            else        launch_a(4, 5000);
            step();
            step();
            chk($sformatf("t3_err%0d", k), err_a, 1);
            chk($sformatf("t3_busy%0d", k), busy_a, 0);
            chk($sformatf("t3_rd_rst%0d", k), ia.rd_rst, 1);
            chk($sformatf("t3_wr_rst%0d", k), ia.wr_rst, 1);
            start_a = 1'b1;
            step();
            start_a = 1'b0;
            chk($sformatf("t3_clr%0d", k), err_a, 0);
            chk($sformatf("t3_idle%0d", k), busy_a, 0);
            step();
            chk($sformatf("t3_nolaunch%0d", k), ia.rd_reload, 0);
        end

        // Drain timeout, W=1 H=1
        launch_a(1, 1);
        step();
        step();
        chk("t4_last", ia.pix_last, 1);
        for (int k = 0; k < 64; k++) step();
        chk("t4_d63_busy", busy_a, 1);
        chk("t4_d63_err", err_a, 0);
        chk("t4_d63_wr_rst", ia.wr_rst, 0);
        step();
        chk("t4_err", err_a, 1);
        chk("t4_rd_rst", ia.rd_rst, 1);
        chk("t4_wr_rst", ia.wr_rst, 1);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("t4_abort_clr", err_a, 0);

        // Early rd_end rising mid-stream
        launch_a(4, 2);
        step();
        step();
        step();
        ia.rd_end = 1'b1;
        step();
        ia.rd_end = 1'b0;
        chk("t5_rd_end_err", err_a, 1);
        start_a = 1'b1;
        step();
        start_a = 1'b0;
        chk("t5_clr", err_a, 0);

        // Abort at pixel 3
        launch_a(4, 2);
        step();
        for (int k = 0; k < 4; k++) step();
        chk("t6_x3", ia.pix_x, 3);
        abort_a = 1'b1;
        step();
        abort_a = 1'b0;
        chk("t6_valid", ia.pix_valid, 0);
        chk("t6_busy", busy_a, 0);
        chk("t6_done", done_a, 0);
        chk("t6_x", ia.pix_x, 0);
        step();
        chk("t6_done_late", done_a, 0);

        // Async reset mid-stream, between edges
        launch_a(4, 2);
        step();
        for (int k = 0; k < 3; k++) step();
        #2 rst = 1'b1;
        #1;
        chk("t7_valid", ia.pix_valid, 0);
        chk("t7_rd_rst", ia.rd_rst, 1);
        chk("t7_wr_rst", ia.wr_rst, 1);
        chk("t7_busy", busy_a, 0);
        chk("t7_x", ia.pix_x, 0);
        #1 rst = 1'b0;
        step();
        chk("t7_idle", busy_a, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
